// File: rtl/alu_issue_pkg.sv
// Shared widths, opcode/ALU encodings and instruction field positions for the
// ID/EX issue stage.
package alu_issue_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int ALU_CON_WIDTH  = 3;
   localparam int REG_ADDR_WIDTH = 3;
   localparam int OPCODE_WIDTH   = 4;
   localparam int IMM_WIDTH      = 6;

   localparam logic [ALU_CON_WIDTH-1:0] ALU_ADD = 3'd0;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_AND = 3'd2;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_OR  = 3'd3;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_XOR = 3'd4;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_SHL = 3'd5;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_SHR = 3'd6;
   localparam logic [ALU_CON_WIDTH-1:0] ALU_SRA = 3'd7;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 4'd0;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 4'd1;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 4'd2;
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 4'd3;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 4'd4;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 4'd5;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 4'd6;

   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int RS_HI    = 11;
   localparam int RS_LO    = 9;
   localparam int RT_HI    = 8;
   localparam int RT_LO    = 6;
   localparam int RD_HI    = 5;
   localparam int RD_LO    = 3;
   localparam int FUNCT_HI = 2;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 5;
   localparam int IMM_LO   = 0;

   typedef struct packed {
      logic                      valid;
      logic [ALU_CON_WIDTH-1:0]  aluCon;
      logic [DATA_WIDTH-1:0]     opA;
      logic [DATA_WIDTH-1:0]     opB;
      logic [DATA_WIDTH-1:0]     storeData;
      logic [REG_ADDR_WIDTH-1:0] destReg;
      logic                      regWrite;
      logic                      memRead;
      logic                      memWrite;
   } idex_t;

   typedef struct packed {
      logic [ALU_CON_WIDTH-1:0]  aluCon;
      logic                      bIsRt;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] dest;
      logic                      regWrite;
      logic                      memRead;
      logic                      memWrite;
      logic                      rsUsed;
      logic                      rtUsed;
   } decode_t;

   function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] imm);
      return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] zext_imm(input logic [IMM_WIDTH-1:0] imm);
      return {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_forward.sv
// Three-way operand source select: EX/MEM result, MEM/WB data, or register file.
// Register 0 is hard-wired to zero and never takes a forwarded value.
module alu_issue_forward
   import alu_issue_pkg::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0]     rfData_i,
   input  logic                      exMemRegWrite_i,
   input  logic [REG_ADDR_WIDTH-1:0] exMemRd_i,
   input  logic [DATA_WIDTH-1:0]     exMemResult_i,
   input  logic                      memWbRegWrite_i,
   input  logic [REG_ADDR_WIDTH-1:0] memWbRd_i,
   input  logic [DATA_WIDTH-1:0]     memWbData_i,
   output logic [DATA_WIDTH-1:0]     data_o
);

   always_comb begin
      if (addr_i == '0)
         data_o = '0;
      else if (exMemRegWrite_i && (exMemRd_i == addr_i))
         data_o = exMemResult_i;
      else if (memWbRegWrite_i && (memWbRd_i == addr_i))
         data_o = memWbData_i;
      else
         data_o = rfData_i;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes the instruction, forwards operands, detects load-use
// hazards and registers the ALU inputs and control for the following cycle.
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic                      clk,
   input  logic                      rstN,
   input  logic [15:0]               instr,
   input  logic                      instrValid,
   output logic [REG_ADDR_WIDTH-1:0] raddrA,
   output logic [REG_ADDR_WIDTH-1:0] raddrB,
   input  logic [DATA_WIDTH-1:0]     rdataA,
   input  logic [DATA_WIDTH-1:0]     rdataB,
   input  logic                      exMemRegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] exMemRd,
   input  logic [DATA_WIDTH-1:0]     exMemResult,
   input  logic                      memWbRegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] memWbRd,
   input  logic [DATA_WIDTH-1:0]     memWbData,
   input  logic                      holdIn,
   input  logic                      flush,
   output logic                      stallOut,
   output logic                      exValid,
   output logic [ALU_CON_WIDTH-1:0]  exAluCon,
   output logic [DATA_WIDTH-1:0]     exOperandA,
   output logic [DATA_WIDTH-1:0]     exOperandB,
   output logic [DATA_WIDTH-1:0]     exStoreData,
   output logic [REG_ADDR_WIDTH-1:0] exDestReg,
   output logic                      exRegWrite,
   output logic                      exMemRead,
   output logic                      exMemWrite
);

   logic [OPCODE_WIDTH-1:0]   op;
   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
   logic [ALU_CON_WIDTH-1:0]  funct;
   logic [IMM_WIDTH-1:0]      imm6;
   logic [DATA_WIDTH-1:0]     fwdA, fwdB;
   decode_t                   dec;
   idex_t                     ex_q, ex_d;
   logic                      rsHit, rtHit;

   assign op    = instr[OP_HI:OP_LO];
   assign rs    = instr[RS_HI:RS_LO];
   assign rt    = instr[RT_HI:RT_LO];
   assign rd    = instr[RD_HI:RD_LO];
   assign funct = instr[FUNCT_HI:FUNCT_LO];
   assign imm6  = instr[IMM_HI:IMM_LO];

   assign raddrA = rs;
   assign raddrB = rt;

   alu_issue_forward u_fwd_rs (
      .addr_i          (rs),
      .rfData_i        (rdataA),
      .exMemRegWrite_i (exMemRegWrite),
      .exMemRd_i       (exMemRd),
      .exMemResult_i   (exMemResult),
      .memWbRegWrite_i (memWbRegWrite),
      .memWbRd_i       (memWbRd),
      .memWbData_i     (memWbData),
      .data_o          (fwdA)
   );

   alu_issue_forward u_fwd_rt (
      .addr_i          (rt),
      .rfData_i        (rdataB),
      .exMemRegWrite_i (exMemRegWrite),
      .exMemRd_i       (exMemRd),
      .exMemResult_i   (exMemResult),
      .memWbRegWrite_i (memWbRegWrite),
      .memWbRd_i       (memWbRd),
      .memWbData_i     (memWbData),
      .data_o          (fwdB)
   );

   always_comb begin
      dec        = '0;
      dec.aluCon = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            dec.aluCon = funct; dec.bIsRt = 1'b1; dec.dest = rd;
            dec.regWrite = 1'b1; dec.rsUsed = 1'b1; dec.rtUsed = 1'b1;
         end
         OP_ADDI: begin
            dec.imm = sext_imm(imm6); dec.dest = rt;
            dec.regWrite = 1'b1; dec.rsUsed = 1'b1;
         end
         OP_ANDI: begin
            dec.aluCon = ALU_AND; dec.imm = zext_imm(imm6); dec.dest = rt;
            dec.regWrite = 1'b1; dec.rsUsed = 1'b1;
         end
         OP_ORI: begin
            dec.aluCon = ALU_OR; dec.imm = zext_imm(imm6); dec.dest = rt;
            dec.regWrite = 1'b1; dec.rsUsed = 1'b1;
         end
         OP_LW: begin
            dec.imm = sext_imm(imm6); dec.dest = rt;
            dec.regWrite = 1'b1; dec.memRead = 1'b1; dec.rsUsed = 1'b1;
         end
         OP_SW: begin
            dec.imm = sext_imm(imm6); dec.memWrite = 1'b1;
            dec.rsUsed = 1'b1; dec.rtUsed = 1'b1;
         end
         OP_BEQ: begin
            dec.aluCon = ALU_SUB; dec.bIsRt = 1'b1;
            dec.rsUsed = 1'b1; dec.rtUsed = 1'b1;
         end
         default: ;
      endcase
   end

   // Load in EX whose destination is read by the instruction now in ID.
   assign rsHit = dec.rsUsed && (rs == ex_q.destReg);
   assign rtHit = dec.rtUsed && (rt == ex_q.destReg);
   assign stallOut = ex_q.valid && ex_q.memRead && (ex_q.destReg != '0) &&
                     instrValid && (rsHit || rtHit) && !flush && !holdIn;

   always_comb begin
      ex_d = ex_q;
      if (holdIn) begin
         ex_d = ex_q;
      end else if (flush || stallOut) begin
         ex_d = '0;
      end else begin
         ex_d.valid     = instrValid;
         ex_d.aluCon    = dec.aluCon;
         ex_d.opA       = fwdA;
         ex_d.opB       = dec.bIsRt ? fwdB : dec.imm;
         ex_d.storeData = fwdB;
         ex_d.destReg   = dec.dest;
         ex_d.regWrite  = dec.regWrite && instrValid;
         ex_d.memRead   = dec.memRead  && instrValid;
         ex_d.memWrite  = dec.memWrite && instrValid;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign exValid     = ex_q.valid;
   assign exAluCon    = ex_q.aluCon;
   assign exOperandA  = ex_q.opA;
   assign exOperandB  = ex_q.opB;
   assign exStoreData = ex_q.storeData;
   assign exDestReg   = ex_q.destReg;
   assign exRegWrite  = ex_q.regWrite;
   assign exMemRead   = ex_q.memRead;
   assign exMemWrite  = ex_q.memWrite;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver predicts each ID/EX load from
// the decode/forwarding/hazard rules and a monitor compares after every edge.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] instr;
   logic        instrValid;
   logic [2:0]  raddrA, raddrB;
   logic [15:0] rdataA, rdataB;
   logic        exMemRegWrite;
   logic [2:0]  exMemRd;
   logic [15:0] exMemResult;
   logic        memWbRegWrite;
   logic [2:0]  memWbRd;
   logic [15:0] memWbData;
   logic        holdIn, flush;
   logic        stallOut, exValid;
   logic [2:0]  exAluCon;
   logic [15:0] exOperandA, exOperandB, exStoreData;
   logic [2:0]  exDestReg;
   logic        exRegWrite, exMemRead, exMemWrite;

   alu_issue_stage dut (
      .clk(clk), .rstN(rstN), .instr(instr), .instrValid(instrValid),
      .raddrA(raddrA), .raddrB(raddrB), .rdataA(rdataA), .rdataB(rdataB),
      .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemResult(exMemResult),
      .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
      .holdIn(holdIn), .flush(flush), .stallOut(stallOut), .exValid(exValid),
      .exAluCon(exAluCon), .exOperandA(exOperandA), .exOperandB(exOperandB),
      .exStoreData(exStoreData), .exDestReg(exDestReg), .exRegWrite(exRegWrite),
      .exMemRead(exMemRead), .exMemWrite(exMemWrite)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit [2:0]  alu;
      bit [15:0] a, b, st;
      bit [2:0]  d;
      bit        rw, mr, mw;
      bit        chkData;
      bit        chkSt;
   } exp_t;

   exp_t      q[$];
   exp_t      last;
   int        checks = 0;
   int        errors = 0;
   bit [15:0] rf [8];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit [15:0] fwd(input bit [2:0] a, input bit [15:0] rfv);
      if (a == 0) return 16'h0;
      if (exMemRegWrite && exMemRd == a) return exMemResult;
      if (memWbRegWrite && memWbRd == a) return memWbData;
      return rfv;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e = '{default: 0};
      e.chkData = 1'b1;
      e.chkSt   = 1'b1;
      return e;
   endfunction

   // Present one instruction at the falling edge and predict the ID/EX contents.
   task automatic step(input bit [15:0] ins, input bit v, input bit h, input bit f,
                       input bit exW, input bit [2:0] exRd, input bit [15:0] exRes,
                       input bit wbW, input bit [2:0] wbRd, input bit [15:0] wbD);
      bit [3:0]  op;
      bit [2:0]  rs, rt;
      bit        usesRs, usesRt, stall;
      bit [15:0] aval, tval;
      exp_t      e;
      @(negedge clk);
      instr = ins; instrValid = v; holdIn = h; flush = f;
      exMemRegWrite = exW; exMemRd = exRd; exMemResult = exRes;
      memWbRegWrite = wbW; memWbRd = wbRd; memWbData = wbD;
      rdataA = rf[ins[11:9]]; rdataB = rf[ins[8:6]];
      #1;
      op = ins[15:12]; rs = ins[11:9]; rt = ins[8:6];
      usesRs = (op <= 6);
      usesRt = (op == 0) || (op == 5) || (op == 6);
      stall = last.v && last.mr && (last.d != 0) && v &&
              ((usesRs && rs == last.d) || (usesRt && rt == last.d)) && !f && !h;
      chk("stallOut", {15'b0, stallOut}, {15'b0, stall});
      chk("raddrA", {13'b0, raddrA}, {13'b0, rs});
      chk("raddrB", {13'b0, raddrB}, {13'b0, rt});
      if (h) e = last;
      else if (f || stall) e = zero_exp();
      else begin
         e = '{default: 0};
         aval = fwd(rs, rf[rs]);
         tval = fwd(rt, rf[rt]);
         e.v = v; e.a = aval; e.st = tval;
         e.chkData = v && (op <= 6);
         e.chkSt   = v && usesRt;
         case (op)
            0: begin e.alu = ins[2:0]; e.b = tval; e.d = ins[5:3]; e.rw = 1; end
            1: begin e.b = {{10{ins[5]}}, ins[5:0]}; e.d = rt; e.rw = 1; end
            2: begin e.alu = 2; e.b = {10'b0, ins[5:0]}; e.d = rt; e.rw = 1; end
            3: begin e.alu = 3; e.b = {10'b0, ins[5:0]}; e.d = rt; e.rw = 1; end
            4: begin e.b = {{10{ins[5]}}, ins[5:0]}; e.d = rt; e.rw = 1; e.mr = 1; end
            5: begin e.b = {{10{ins[5]}}, ins[5:0]}; e.mw = 1; end
            6: begin e.alu = 1; e.b = tval; end
            default: ;
         endcase
         if (!v) begin e.rw = 0; e.mr = 0; e.mw = 0; end
      end
      last = e;
      q.push_back(e);
   endtask

   task automatic simple(input bit [15:0] ins, input bit h, input bit f);
      step(ins, 1, h, f, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_exValid"}, {15'b0, exValid}, 16'h0);
      chk({tag, "_exAluCon"}, {13'b0, exAluCon}, 16'h0);
      chk({tag, "_exOperandA"}, exOperandA, 16'h0);
      chk({tag, "_exOperandB"}, exOperandB, 16'h0);
      chk({tag, "_exStoreData"}, exStoreData, 16'h0);
      chk({tag, "_exDestReg"}, {13'b0, exDestReg}, 16'h0);
      chk({tag, "_ctrl"}, {13'b0, exRegWrite, exMemRead, exMemWrite}, 16'h0);
      chk({tag, "_stallOut"}, {15'b0, stallOut}, 16'h0);
   endtask

   // Monitor: compare every predicted ID/EX load just after its clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("exValid", {15'b0, exValid}, {15'b0, e.v});
            chk("exRegWrite", {15'b0, exRegWrite}, {15'b0, e.rw});
            chk("exMemRead", {15'b0, exMemRead}, {15'b0, e.mr});
            chk("exMemWrite", {15'b0, exMemWrite}, {15'b0, e.mw});
            if (e.v || e.chkData) chk("exAluCon", {13'b0, exAluCon}, {13'b0, e.alu});
            if (e.chkData) begin
               chk("exOperandA", exOperandA, e.a);
               chk("exOperandB", exOperandB, e.b);
               chk("exDestReg", {13'b0, exDestReg}, {13'b0, e.d});
            end
            if (e.chkSt) chk("exStoreData", exStoreData, e.st);
         end
      end
   end

   initial begin
      rstN = 1'b0; instr = 16'h0; instrValid = 1'b0; rdataA = 0; rdataB = 0;
      exMemRegWrite = 0; exMemRd = 0; exMemResult = 0;
      memWbRegWrite = 0; memWbRd = 0; memWbData = 0; holdIn = 0; flush = 0;
      last = '{default: 0};
      for (int i = 0; i < 8; i++) rf[i] = 16'h0;
      repeat (2) @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rstN = 1'b1;

      rf[0] = 16'h1234; rf[1] = 16'd5; rf[2] = 16'd7;
      simple(16'h0298, 0, 0);                    // add r3 = r1 + r2
      rf[1] = 16'd10;
      simple(16'h133F, 0, 0);                    // addi r4 = r1 + (-1)
      simple(16'h233F, 0, 0);                    // andi r4 = r1 & 0x3f
      step(16'h0298, 1, 0, 0, 1, 1, 16'h1111, 1, 1, 16'h2222);
      step(16'h0298, 1, 0, 0, 0, 1, 16'h1111, 1, 1, 16'h2222);
      step(16'h0098, 1, 0, 0, 1, 0, 16'h1111, 1, 0, 16'h2222);
      simple(16'h4284, 0, 0);                    // lw r2, 4(r1)
      simple(16'h0298, 0, 0);                    // add needing r2: stalls
      step(16'h0298, 1, 0, 0, 0, 0, 0, 1, 2, 16'hBEEF);
      simple(16'h5284, 0, 0);                    // sw r2, 4(r1)
      simple(16'h6298, 1, 0);                    // hold x3 with changing instr
      simple(16'h1111, 1, 0);
      simple(16'h0AAA, 1, 1);                    // hold beats flush
      simple(16'h0298, 0, 1);                    // flush alone
      simple(16'hF123, 0, 0);                    // NOP opcode
      step(16'h0298, 0, 0, 0, 0, 0, 0, 0, 0, 0); // invalid instr

      for (int n = 0; n < 400; n++) begin
         bit [15:0] ins;
         for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
         ins = 16'($urandom);
         if ($urandom_range(3) != 0) ins[15:12] = 4'($urandom_range(6));
         ins[11:9] = 3'($urandom_range(3));
         ins[8:6]  = 3'($urandom_range(3));
         step(ins, $urandom_range(9) != 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
              1'($urandom), 3'($urandom_range(3)), 16'($urandom),
              1'($urandom), 3'($urandom_range(3)), 16'($urandom));
      end

      // Asynchronous reset while a load-use stall is pending.
      simple(16'h4284, 0, 0);
      @(negedge clk);
      instr = 16'h0298; instrValid = 1; holdIn = 0; flush = 0;
      #1 chk("preReset_stallOut", {15'b0, stallOut}, 16'h1);
      rstN = 1'b0;
      #1 check_all_zero("asyncReset");
      q.delete();
      last = '{default: 0};
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      simple(16'h0298, 0, 0);                    // no hazard right after reset
      simple(16'h0000, 0, 0);
      @(negedge clk);
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the ALU's inputs: the 3-bit ALU control and two 16-bit operands.
- Decodes a 16-bit instruction and reads the register file through combinational read-address ports.
- Resolves EX/MEM and MEM/WB forwarding and detects load-use hazards.
- Registers everything into the ID/EX register; that register drives the ALU directly on the next cycle.

Parameters:
DATA_WIDTH, 16, operand/result width
ALU_CON_WIDTH, 3, ALU control width (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 sra)
REG_ADDR_WIDTH, 3, register index width (8 registers)

Ports:
clk  in  1  rising-edge clock
rstN  in  1  asynchronous, active-low reset
instr  in  16  instruction from IF/ID
instrValid  in  1  instr holds a real instruction
raddrA  out  3  register-file read address = instr[11:9] (rs), combinational
raddrB  out  3  register-file read address = instr[8:6] (rt), combinational
rdataA  in  16  register-file data for raddrA
rdataB  in  16  register-file data for raddrB
exMemRegWrite  in  1  EX/MEM stage writes a register
exMemRd  in  3  EX/MEM destination register
exMemResult  in  16  EX/MEM ALU result
memWbRegWrite  in  1  MEM/WB stage writes a register
memWbRd  in  3  MEM/WB destination register
memWbData  in  16  MEM/WB write-back data
holdIn  in  1  downstream stall: freeze ID/EX register
flush  in  1  branch flush: load a bubble
stallOut  out  1  load-use stall request to IF/ID and PC, combinational
exValid  out  1  ID/EX holds a valid instruction
exAluCon  out  3  ALU control
exOperandA  out  16  ALU operand A
exOperandB  out  16  ALU operand B
exStoreData  out  16  forwarded rt value, used by SW
exDestReg  out  3  write-back register
exRegWrite, exMemRead, exMemWrite  out  1 each  control bits

Behaviour:
- Reset (rstN low, asynchronous): every registered output is 0. stallOut then evaluates to 0.
- Encoding:
  - op = instr[15:12], rs = [11:9], rt = [8:6], rd = [5:3], funct = [2:0], imm6 = [5:0] sign-extended to 16 bits.
- Decode table (op: aluCon, B operand, dest, control bits):
  - op 0 R-type: aluCon = funct; B = rt value; dest = rd; regWrite.
  - op 1 ADDI: aluCon 0; B = imm; dest = rt; regWrite.
  - op 2 ANDI: aluCon 2; B = zero-extended imm6; dest = rt; regWrite.
  - op 3 ORI: aluCon 3; B = zero-extended imm6; dest = rt; regWrite.
  - op 4 LW: aluCon 0; B = imm; dest = rt; regWrite, memRead.
  - op 5 SW: aluCon 0; B = imm; memWrite; storeData = rt value.
  - op 6 BEQ: aluCon 1; B = rt value; no writes.
  - ops 7–15: NOP. Valid but all control bits 0, aluCon 0.
- Uses of rs/rt:
  - rs is used by ops 0–6.
  - rt is used by ops 0, 5 and 6.
- Forwarding, per source operand:
  - If exMemRegWrite and exMemRd matches and the address is nonzero, take exMemResult.
  - Else if memWbRegWrite and memWbRd matches and the address is nonzero, take memWbData.
  - Else take the register-file value.
  - EX/MEM has priority over MEM/WB.
  - Register 0 always reads as 0; it is never forwarded.
- Load-use hazard:
  - stallOut = exValid & exMemRead & (exDestReg != 0) & instrValid & (used rs or used rt equals exDestReg) & !flush & !holdIn.
- Register update priority on each rising edge:
  1. holdIn: all ID/EX outputs hold.
  2. flush: bubble (exValid = 0, all control bits 0; data outputs don't-care, implemented as 0).
  3. stallOut: bubble.
  4. Otherwise load the decoded instruction, with exValid = instrValid.
- Invalid instruction: if instrValid = 0, control bits load as 0.
- Latency: one cycle from instr to ex* outputs.
- Hold interaction: when holdIn and flush are both asserted, holdIn wins, and flush must be re-asserted by the branch unit.
- Reset mid-stream: all in-flight state is dropped; the first instruction after reset has no hazard.

Decomposition:
- Shared package holds:
  - ALU control constants ALU_ADD … ALU_SRA (values 0–7).
  - Opcode constants OP_RTYPE … OP_BEQ.
  - Field bit-position localparams.
  - The width parameters.
- One sub-module, alu_issue_forward: combinational 3-way operand forwarding mux, instantiated twice (rs, rt).
- Decode, hazard logic and the ID/EX register stay in the top level.

Test Plan:
- Reset with instr = 0x0000 held → every output 0, stallOut 0. Release reset, apply R-type add r3 = r1 + r2 with rdataA 5, rdataB 7 → next cycle exAluCon 0, A 5, B 7, exDestReg 3, exRegWrite 1.
- ADDI with imm6 = 0x3F, rs value 10 → exOperandB 0xFFFF, aluCon 0. ANDI with imm6 = 0x3F → exOperandB 0x003F.
- Forwarding: exMemRd = 1 with exMemResult 0x1111, memWbRd = 1 with memWbData 0x2222, instr rs = 1 → A = 0x1111. Drop exMemRegWrite → A = 0x2222. Set rs = 0 → A = 0.
- Load-use: LW r2 issued, next instruction add uses rt = r2 → stallOut 1 for one cycle and a bubble enters ID/EX (exValid 0). The following cycle the add issues with r2 taken via memWb or exMem forwarding.
- holdIn asserted for 3 cycles while instr changes → outputs frozen. flush together with holdIn → hold wins. flush alone → exValid 0 and all control bits 0.
- Assert rstN low mid-stream with exMemRead set → outputs clear immediately without waiting for a clock edge, and stallOut drops to 0.
